// File: rtl/puf_response_collector.sv
// Ring-oscillator PUF response collector: sequences counter clear/window/settle/sample per pair and packs the bits.
// Macro PUF_MAJORITY_VOTE_EN enables VOTES-way majority per bit; otherwise each bit is a single sample.
module puf_response_collector #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int RESP_BITS     = 16,
  parameter int VOTES         = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         puf_bit,
  output logic                         cnt_clear,
  output logic                         cnt_enable,
  output logic [$clog2(RESP_BITS)-1:0] pair_sel,
  output logic                         busy,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [RESP_BITS-1:0]         resp_data
);

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VOTES_EFF = VOTES;
`else
  localparam int VOTES_EFF = (VOTES > 0) ? 1 : 1;
`endif
  localparam int PW = $clog2(RESP_BITS);
  localparam int VW = (VOTES_EFF > 1) ? $clog2(VOTES_EFF) : 1;
  localparam int OW = $clog2(VOTES_EFF + 1);
  localparam int TW = $clog2(WINDOW_CYCLES + 2);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] COUNT  = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] SAMPLE = 3'd4;
  localparam logic [2:0] OUTPUT = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [PW-1:0]        bit_idx_q, bit_idx_d;
  logic [VW-1:0]        vote_q, vote_d;
  logic [OW-1:0]        ones_q, ones_d;
  logic [RESP_BITS-1:0] shadow_q, shadow_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [OW-1:0]        ones_sum;
  logic                 maj_bit;
  logic [RESP_BITS-1:0] shadow_upd;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    vote_d    = vote_q;
    ones_d    = ones_q;
    shadow_d  = shadow_q;
    resp_d    = resp_q;
    // Tally includes the sample taken this cycle, so the final vote decides immediately.
    ones_sum  = ones_q + OW'(puf_bit);
    maj_bit   = (ones_sum > OW'(VOTES_EFF / 2));
    shadow_upd = shadow_q;
    shadow_upd[bit_idx_q] = maj_bit;

    case (state_q)
      IDLE: begin
        if (start) begin
          bit_idx_d = '0;
          vote_d    = '0;
          ones_d    = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        timer_d = '0;
        state_d = COUNT;
      end
      COUNT: begin
        if (timer_q == TW'(WINDOW_CYCLES - 1)) begin
          timer_d = '0;
          state_d = SETTLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SETTLE: begin
        if (timer_q == TW'(1)) begin
          timer_d = '0;
          state_d = SAMPLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SAMPLE: begin
        if (vote_q == VW'(VOTES_EFF - 1)) begin
          shadow_d = shadow_upd;
          vote_d   = '0;
          ones_d   = '0;
          if (bit_idx_q == PW'(RESP_BITS - 1)) begin
            resp_d  = shadow_upd;
            state_d = OUTPUT;
          end else begin
            bit_idx_d = bit_idx_q + PW'(1);
            state_d   = CLEAR;
          end
        end else begin
          ones_d  = ones_sum;
          vote_d  = vote_q + VW'(1);
          state_d = CLEAR;
        end
      end
      OUTPUT: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      vote_q    <= '0;
      ones_q    <= '0;
      shadow_q  <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      vote_q    <= vote_d;
      ones_q    <= ones_d;
      shadow_q  <= shadow_d;
      resp_q    <= resp_d;
    end
  end

  // All outputs decode from registered state only, so they are glitch-free and input-independent.
  assign cnt_clear  = (state_q == CLEAR);
  assign cnt_enable = (state_q == COUNT);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == OUTPUT);
  assign pair_sel   = bit_idx_q;
  assign resp_data  = resp_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// Bench for puf_response_collector: measurement-schedule reference model with per-cycle compare plus literal checks.
module tb_puf_response_collector;
  localparam int W = 8;
  localparam int B = 4;
  localparam int V = 3;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int EV = V;
  localparam int EXP_LAT = 145;
  localparam logic [B-1:0] EXP_PAT = 4'h5;
`else
  localparam int EV = 1;
  localparam int EXP_LAT = 49;
  localparam logic [B-1:0] EXP_PAT = 4'hD;
`endif
  localparam int MW = W + 4;
  localparam int TOTAL = B * EV * MW;
  localparam int LIMIT = TOTAL + 50;

  logic clk = 1'b0;
  logic rst, start, puf_bit, resp_ready;
  logic cnt_clear, cnt_enable, busy, resp_valid;
  logic [1:0] pair_sel;
  logic [B-1:0] resp_data;

  puf_response_collector #(.WINDOW_CYCLES(W), .RESP_BITS(B), .VOTES(V)) dut (
    .clk(clk), .rst(rst), .start(start), .puf_bit(puf_bit),
    .cnt_clear(cnt_clear), .cnt_enable(cnt_enable), .pair_sel(pair_sel),
    .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int c0 = 0;
  bit chk_on = 1'b0;
  int puf_mode = 1;
  bit puf_const = 1'b0;
  bit pat_a [0:B*V-1];

  // Reference model: mode 0 idle, 1 measuring (m_t = 1..TOTAL cycles into the run), 2 response offered
  int m_mode = 0;
  int m_t = 0;
  int m_pair = 0;
  logic [B-1:0] m_resp = '0;
  bit samp [0:B*V-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_t <= 0; m_pair <= 0; m_resp <= '0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode <= 1; m_t <= 1; end
        1: begin
          if ((m_t - 1) % MW == MW - 1) samp[(m_t - 1) / MW] <= puf_bit;
          if (m_t == TOTAL) begin
            automatic bit s [0:B*V-1];
            automatic logic [B-1:0] r = '0;
            for (int i = 0; i < B * V; i++) s[i] = samp[i];
            s[B * EV - 1] = puf_bit;
            for (int k = 0; k < B; k++) begin
              automatic int ones = 0;
              for (int v = 0; v < EV; v++) ones += int'(s[k * EV + v]);
              r[k] = (2 * ones > EV);
            end
            m_resp <= r; m_mode <= 2; m_pair <= B - 1;
          end else begin
            m_t <= m_t + 1;
          end
        end
        default: if (resp_ready) m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    case (puf_mode)
      0: puf_bit = 1'($urandom_range(0, 1));
      1: puf_bit = puf_const;
      default: puf_bit = (m_mode == 1) ? pat_a[(m_t - 1) / MW] : 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (chk_on) begin
      automatic int ph = (m_t - 1) % MW;
      automatic int ep = (m_mode == 1) ? ((m_t - 1) / MW) / EV : m_pair;
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("resp_valid", 32'(resp_valid), 32'(m_mode == 2));
      chk("cnt_clear", 32'(cnt_clear), 32'(m_mode == 1 && ph == 0));
      chk("cnt_enable", 32'(cnt_enable), 32'(m_mode == 1 && ph >= 1 && ph <= W));
      chk("pair_sel", 32'(pair_sel), 32'(ep));
      chk("resp_data", 32'(resp_data), 32'(m_resp));
      chk("clr_en_excl", 32'(cnt_clear & cnt_enable), 32'd0);
    end
  end

  // Each complete counting window must be exactly W cycles long
  int en_run = 0;
  always @(negedge clk) begin
    if (cnt_enable === 1'b1) en_run++;
    else if (en_run != 0) begin
      if (chk_on && m_mode == 1) chk("en_window_len", 32'(en_run), 32'(W));
      en_run = 0;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_start();
    start = 1'b1; c0 = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int n = 0;
    while (resp_valid !== 1'b1 && n < LIMIT) begin step(1); n++; end
    if (resp_valid !== 1'b1) chk("valid_timeout", 32'd0, 32'd1);
    lat = cyc - c0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    step(1);
    resp_ready = 1'b0;
    chk("idle_after_ready", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
`ifdef PUF_MAJORITY_VOTE_EN
    pat_a = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    pat_a = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1; start = 1'b0; resp_ready = 1'b0; puf_bit = 1'b0;
    step(3);
    rst = 1'b0; chk_on = 1'b1;

    // Idle after reset
    step(20);
    chk("reset_outputs", {busy, resp_valid, cnt_clear, cnt_enable, pair_sel, resp_data}, 32'd0);

    // All-ones response and latency
    puf_mode = 1; puf_const = 1'b1;
    run_start();
    wait_valid(lat);
    chk("latency_ones", 32'(lat), 32'(EXP_LAT));
    chk("data_ones", 32'(resp_data), 32'hF);
    handshake();

    // Fixed vote pattern, then backpressure with ignored starts
    puf_mode = 2;
    run_start();
    wait_valid(lat);
    chk("latency_pat", 32'(lat), 32'(EXP_LAT));
    chk("data_pat", 32'(resp_data), 32'(EXP_PAT));
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      step(1);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", 32'(resp_data), 32'(EXP_PAT));
    end
    start = 1'b0;
    handshake();
    chk("valid_dropped", 32'(resp_valid), 32'd0);
    step(2);
    chk("data_held", 32'(resp_data), 32'(EXP_PAT));

    // Reset in the middle of pair 2's counting window
    puf_mode = 0;
    run_start();
    begin
      int n = 0;
      while (!(m_mode == 1 && ((m_t - 1) / MW) / EV == 2 && (m_t - 1) % MW == 4) && n < LIMIT) begin
        step(1); n++;
      end
    end
    chk("pre_rst_pair", 32'(pair_sel), 32'd2);
    chk("pre_rst_en", 32'(cnt_enable), 32'd1);
    rst = 1'b1;
    step(1);
    chk("post_rst_outputs", {busy, resp_valid, cnt_clear, cnt_enable, pair_sel, resp_data}, 32'd0);
    rst = 1'b0;
    run_start();
    chk("restart_clear", 32'(cnt_clear), 32'd1);
    chk("restart_pair", 32'(pair_sel), 32'd0);
    wait_valid(lat);
    chk("latency_restart", 32'(lat), 32'(EXP_LAT));
    handshake();

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      puf_mode = 0;
      step($urandom_range(0, 3));
      run_start();
      if (r == 3) begin
        step($urandom_range(5, TOTAL - 5));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rand_rst_busy", 32'(busy), 32'd0);
        continue;
      end
      wait_valid(lat);
      chk("latency_rand", 32'(lat), 32'(EXP_LAT));
      for (int d = $urandom_range(0, 5); d > 0; d--) begin
        start = 1'($urandom_range(0, 1));
        step(1);
      end
      start = 1'b0;
      handshake();
    end

    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 Parameter WINDOW_CYCLES, default 1024: cnt_enable high-time per measurement, in clk cycles; SHALL be >= 1.
REQ-002 Parameter RESP_BITS, default 16: response width, which is also the number of RO pairs measured; SHALL be >= 2.
REQ-003 Parameter VOTES, default 5: measurements per response bit; SHALL be odd and >= 1.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one full response; sampled only in IDLE.
REQ-007 puf_bit  input  1  comparator result for the selected pair; A faster = 1.
REQ-008 cnt_clear  output  1  one-cycle clear pulse to both frequency counters.
REQ-009 cnt_enable  output  1  counting-window enable to both frequency counters.
REQ-010 pair_sel  output  $clog2(RESP_BITS)  index of the RO pair under measurement.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_data  output  RESP_BITS  collected response; bit k = result of pair k.

Function
REQ-015 States SHALL be IDLE, CLEAR, COUNT, SETTLE, SAMPLE, OUTPUT.
REQ-016 IDLE with start=1: clear bit_idx, vote_idx and the ones counter, then go to CLEAR; start=0 stays in IDLE.
REQ-017 CLEAR lasts 1 cycle with cnt_clear=1, then goes to COUNT.
REQ-018 COUNT holds cnt_enable=1 for exactly WINDOW_CYCLES cycles, then goes to SETTLE.
REQ-019 SETTLE lasts exactly 2 cycles with cnt_enable=0, then goes to SAMPLE.
REQ-020 SAMPLE lasts 1 cycle and adds puf_bit to the ones counter, which is $clog2(VOTES+1) bits wide.
REQ-021 SAMPLE, vote not final: vote_idx++, then go to CLEAR.
REQ-022 SAMPLE, vote_idx=VOTES-1: write bit (ones incl. current sample > VOTES/2) to shadow[bit_idx]; reset vote_idx and ones.
REQ-023 After the final vote with bit_idx<RESP_BITS-1: bit_idx++, then go to CLEAR; with bit_idx=RESP_BITS-1: load resp_data from the shadow register, then go to OUTPUT.
REQ-024 pair_sel SHALL equal bit_idx at all times, so it is stable throughout CLEAR/COUNT/SETTLE/SAMPLE.
REQ-025 OUTPUT asserts resp_valid=1 with resp_data held constant; resp_ready=1 goes to IDLE and drops resp_valid the next cycle.
REQ-026 start SHALL be ignored outside IDLE, including during OUTPUT backpressure.
REQ-027 resp_data SHALL keep its last value after the handshake until the next load.
REQ-028 Latency: one measurement = WINDOW_CYCLES+4 cycles; start seen in IDLE at cycle 0 gives resp_valid high at cycle RESP_BITS*VOTES*(WINDOW_CYCLES+4)+1.
REQ-029 cnt_clear and cnt_enable SHALL never be high in the same cycle.

Reset
REQ-030 rst=1 at any state, including mid-COUNT and OUTPUT: next state IDLE; all outputs 0; counters, indices and shadow cleared.
REQ-031 A start following a reset SHALL begin at pair 0, vote 0.

Configuration
REQ-032 Macro PUF_MAJORITY_VOTE_EN defined: VOTES-way majority as in REQ-020..REQ-022.
REQ-033 Macro PUF_MAJORITY_VOTE_EN undefined: VOTES is treated as 1 and each bit is the single SAMPLE value; latency uses VOTES=1.

Verification (WINDOW_CYCLES=8, RESP_BITS=4, VOTES=3 unless stated)
REQ-034 Reset, no start -> all outputs 0 and busy=0 for 20 cycles.
REQ-035 puf_bit held 1, start at cycle 0 -> resp_valid at cycle 145, resp_data=4'hF, cnt_enable high 8 cycles per window.
REQ-036 Votes per pair 1,0,1 / 0,1,0 / 1,1,0 / 0,0,1 -> resp_data=4'h5.
REQ-037 resp_ready low 10 cycles with start pulses during OUTPUT -> valid/data held, starts ignored; ready=1 -> IDLE next cycle, busy=0.
REQ-038 rst pulsed mid-COUNT of pair 2 -> all outputs 0 next cycle; new start measures pair_sel=0 first.
REQ-039 Macro undefined, pair samples 1,0,1,1 -> resp_data=4'hD, resp_valid at cycle 49.
